// File: rtl/mw_pipe_stage.sv
// MEM/WB pipeline register with load alignment/extension and writeback result mux.
// Latency: 1 cycle from M-stage inputs to W-stage outputs; ResultW is decoded from registered state only.
// Backpressure: StallW holds every register, FlushW inserts a bubble and overrides StallW; no ready output.
//
// Optional feature macro: MW_PIPE_STAGE_RETIRE_CNT_EN adds the RetireCount output and its counter.
// DATA_WIDTH must be 32: the byte/halfword lane selection assumes a 4-byte word.

module mw_pipe_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallW,
  input  logic                  FlushW,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            Funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] ReadDataM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  input  logic [REG_ADDR_W-1:0] RdM,
  output logic                  ValidW,
  output logic                  RegWriteW,
  output logic [REG_ADDR_W-1:0] RdW,
  output logic [DATA_WIDTH-1:0] ResultW
`ifdef MW_PIPE_STAGE_RETIRE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  RetireCount
`endif
);

  // Result source encodings; 11 is reserved and falls back to the ALU result.
  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Everything the WB stage needs, held as one packed bundle so flush/stall/reset
  // treat the whole instruction uniformly.
  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic [1:0]            result_src;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] read_data;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [REG_ADDR_W-1:0] rd;
  } wb_bundle_t;

  wb_bundle_t m_dat;
  wb_bundle_t w_q;

  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_ext;

  // Gather the MEM-stage inputs into the bundle that gets captured.
  always_comb begin
    m_dat            = '0;
    m_dat.valid      = ValidM;
    m_dat.regwrite   = RegWriteM;
    m_dat.result_src = ResultSrcM;
    m_dat.funct3     = Funct3M;
    m_dat.alu_result = ALUResultM;
    m_dat.read_data  = ReadDataM;
    m_dat.pc_plus4   = PCPlus4M;
    m_dat.rd         = RdM;
  end

  // Stage register: reset clears, flush bubbles (beats stall), stall holds, else capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else if (FlushW) begin
      w_q <= '0;
    end else if (!StallW) begin
      w_q <= m_dat;
    end
  end

  // Pick the addressed byte and halfword lanes out of the raw memory word.
  // Halfword selection uses only offset[1]; misaligned halfword offsets are ignored.
  always_comb begin
    load_byte = w_q.read_data[7:0];
    unique case (w_q.alu_result[1:0])
      2'd0: load_byte = w_q.read_data[7:0];
      2'd1: load_byte = w_q.read_data[15:8];
      2'd2: load_byte = w_q.read_data[23:16];
      2'd3: load_byte = w_q.read_data[31:24];
      default: load_byte = w_q.read_data[7:0];
    endcase
    load_half = w_q.alu_result[1] ? w_q.read_data[31:16] : w_q.read_data[15:0];
  end

  // Sign/zero extend the selected lane; unknown funct3 passes the raw word.
  always_comb begin
    load_ext = w_q.read_data;
    case (w_q.funct3)
      F3_LB:   load_ext = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      F3_LBU:  load_ext = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      F3_LH:   load_ext = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      F3_LHU:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_half};
      F3_LW:   load_ext = w_q.read_data;
      default: load_ext = w_q.read_data;
    endcase
  end

  // Writeback result mux, fed only from registered state.
  always_comb begin
    ResultW = w_q.alu_result;
    case (w_q.result_src)
      SRC_ALU:  ResultW = w_q.alu_result;
      SRC_LOAD: ResultW = load_ext;
      SRC_PC4:  ResultW = w_q.pc_plus4;
      default:  ResultW = w_q.alu_result;
    endcase
  end

  // Qualified W-stage controls; writes to x0 are dropped here so the regfile needs no check.
  always_comb begin
    ValidW    = w_q.valid;
    RegWriteW = w_q.valid & w_q.regwrite & (w_q.rd != '0);
    RdW       = w_q.rd;
  end

`ifdef MW_PIPE_STAGE_RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] retire_cnt_q;

  // Count instructions leaving WB: valid and not stalled, flushed edges included; wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else if (w_q.valid && !StallW) begin
      retire_cnt_q <= retire_cnt_q + 1'b1;
    end
  end

  assign RetireCount = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mw_pipe_stage.sv
module tb_mw_pipe_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          StallW, FlushW, ValidM, RegWriteM;
  logic [1:0]    ResultSrcM;
  logic [2:0]    Funct3M;
  logic [DW-1:0] ALUResultM, ReadDataM, PCPlus4M;
  logic [RW-1:0] RdM;
  logic          ValidW, RegWriteW;
  logic [RW-1:0] RdW;
  logic [DW-1:0] ResultW;
`ifdef MW_PIPE_STAGE_RETIRE_CNT_EN
  logic [CW-1:0] RetireCount;
`endif

  int errors = 0;
  int checks = 0;

  // Reference state: what the W outputs should show, computed when the instruction enters.
  logic          exp_valid;
  logic          exp_rw;
  logic [RW-1:0] exp_rd;
  logic [DW-1:0] exp_res;
  int            exp_cnt;

  mw_pipe_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(RW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .RdW(RdW), .ResultW(ResultW)
`ifdef MW_PIPE_STAGE_RETIRE_CNT_EN
    , .RetireCount(RetireCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Writeback value from the architectural load/result rules, using shifts on the word.
  function automatic logic [DW-1:0] ref_result(input logic [1:0] src, input logic [2:0] f3,
                                               input logic [DW-1:0] alu, input logic [DW-1:0] rd,
                                               input logic [DW-1:0] pc4);
    logic [DW-1:0] bsh, hsh;
    bsh = rd >> (8 * alu[1:0]);
    hsh = rd >> (16 * alu[1]);
    if (src == 2'b10) return pc4;
    if (src != 2'b01) return alu;
    case (f3)
      3'b000:  return {{24{bsh[7]}}, bsh[7:0]};
      3'b100:  return {24'h0, bsh[7:0]};
      3'b001:  return {{16{hsh[15]}}, hsh[15:0]};
      3'b101:  return {16'h0, hsh[15:0]};
      default: return rd;
    endcase
  endfunction

  task automatic model_reset();
    exp_valid = 0; exp_rw = 0; exp_rd = '0; exp_res = '0; exp_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 64'(ValidW), 64'(exp_valid));
    chk({tag, ".rw"},    64'(RegWriteW), 64'(exp_rw));
    chk({tag, ".rd"},    64'(RdW), 64'(exp_rd));
    chk({tag, ".res"},   64'(ResultW), 64'(exp_res));
`ifdef MW_PIPE_STAGE_RETIRE_CNT_EN
    chk({tag, ".cnt"},   64'(RetireCount), 64'(exp_cnt));
`endif
  endtask

  // One clock: update the model from the inputs present at the edge, then check 1ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    if (exp_valid && !StallW) exp_cnt = (exp_cnt + 1) % (1 << CW);
    if (FlushW) begin
      exp_valid = 0; exp_rw = 0; exp_rd = '0; exp_res = '0;
    end else if (!StallW) begin
      exp_valid = ValidM;
      exp_rw    = ValidM && RegWriteM && (RdM != 0);
      exp_rd    = RdM;
      exp_res   = ref_result(ResultSrcM, Funct3M, ALUResultM, ReadDataM, PCPlus4M);
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] src, input logic [2:0] f3,
                       input logic [DW-1:0] alu, input logic [DW-1:0] rdat,
                       input logic [DW-1:0] pc4, input logic [RW-1:0] rd);
    ValidM = v; RegWriteM = w; ResultSrcM = src; Funct3M = f3;
    ALUResultM = alu; ReadDataM = rdat; PCPlus4M = pc4; RdM = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; StallW = 0; FlushW = 0;
    drive(0, 0, 2'b00, 3'b000, '0, '0, '0, '0);
    model_reset();
    #1;
    check_outputs("por");
    @(negedge clk);
    rst_n = 1;

    // Plain ALU writeback.
    drive(1, 1, 2'b00, 3'b010, 32'h1234, 32'hDEAD_BEEF, 32'h40, 5'd5);
    tick("alu");
    chk("alu.res_const", 64'(ResultW), 64'h1234);
    chk("alu.rw_const", 64'(RegWriteW), 64'd1);

    // Load extraction at offset 2 and 0.
    drive(1, 1, 2'b01, 3'b000, 32'h1002, 32'h80FF7F01, 32'h44, 5'd6);
    tick("lb2");  chk("lb2.const", 64'(ResultW), 64'hFFFFFFFF);
    Funct3M = 3'b100;
    tick("lbu2"); chk("lbu2.const", 64'(ResultW), 64'h000000FF);
    Funct3M = 3'b001;
    tick("lh2");  chk("lh2.const", 64'(ResultW), 64'hFFFF80FF);
    Funct3M = 3'b101;
    tick("lhu2"); chk("lhu2.const", 64'(ResultW), 64'h000080FF);
    Funct3M = 3'b000; ALUResultM = 32'h1000;
    tick("lb0");  chk("lb0.const", 64'(ResultW), 64'h00000001);

    // x0 destination and PC+4 result.
    drive(1, 1, 2'b10, 3'b000, 32'h55, 32'h0, 32'h104, 5'd0);
    tick("x0pc");
    chk("x0.rw_const", 64'(RegWriteW), 64'd0);
    chk("pc4.const", 64'(ResultW), 64'h104);

    // Stall with changing inputs, then flush together with stall.
    drive(1, 1, 2'b00, 3'b010, 32'hA5A5, 32'h0, 32'h200, 5'd9);
    tick("pre_stall");
    StallW = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'b00, 3'b010, $urandom, $urandom, $urandom, 5'(i + 1));
      tick("stall");
      chk("stall.hold_const", 64'(ResultW), 64'hA5A5);
    end
    FlushW = 1;
    tick("flush_stall");
    chk("flush.valid_const", 64'(ValidW), 64'd0);
    StallW = 0; FlushW = 0;

    // Asynchronous reset between edges while a valid instruction is in WB.
    drive(1, 1, 2'b00, 3'b000, 32'hCAFE, 32'h0, 32'h0, 5'd3);
    tick("pre_rst");
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_outputs("async_rst");
    #1;
    rst_n = 1;
    ValidM = 0;
    tick("post_rst");

    // 17 valid unstalled retirements wrap a 4-bit counter to 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 2'b00, 3'b000, 32'(i), 32'h0, 32'h0, 5'd1);
      tick("ret");
    end
    ValidM = 0;
    tick("ret_last");
`ifdef MW_PIPE_STAGE_RETIRE_CNT_EN
    chk("retire.wrap_const", 64'(RetireCount), 64'd1);
`endif
    StallW = 1;
    repeat (3) tick("ret_bubble_stall");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom));
      StallW = ($urandom_range(0, 4) == 0);
      FlushW = ($urandom_range(0, 7) == 0);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mw_pipe_stage.md
Name: mw_pipe_stage

Overview:
- Parametrised successor to the MEM/WB pipeline register of the 5-stage RISC-V core.
- Registers the MEM-stage bundle on each clock, with:
  - async active-low reset
  - stall (hold) and flush (bubble insertion)
  - a valid bit
  - load-data alignment and sign/zero extension
  - the writeback result mux
- Sits between the data-memory stage and the register-file write port. Drives the hazard unit's WB-stage forwarding inputs.

Parameters:
- DATA_WIDTH, 32, datapath width; must be 32 for load alignment.
- REG_ADDR_W, 5, register index width.
- CNT_WIDTH, 32, retire counter width; used only with RETIRE_CNT_EN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- StallW  input  1  hold all stage registers
- FlushW  input  1  load a bubble on next edge
- ValidM  input  1  instruction in MEM is real
- RegWriteM  input  1  instruction writes rd
- ResultSrcM  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved
- Funct3M  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ALUResultM  input  DATA_WIDTH  ALU result / load address
- ReadDataM  input  DATA_WIDTH  raw word from data memory
- PCPlus4M  input  DATA_WIDTH  PC+4 of instruction
- RdM  input  REG_ADDR_W  destination register
- ValidW  output  1  WB slot holds a real instruction
- RegWriteW  output  1  qualified register-file write enable
- RdW  output  REG_ADDR_W  destination register
- ResultW  output  DATA_WIDTH  writeback value
- RetireCount  output  CNT_WIDTH  retired-instruction count; present only with RETIRE_CNT_EN

Behaviour:
- Reset (rst_n=0, async): all internal registers cleared.
  - ValidW=0, RegWriteW=0, RdW=0, ResultW=0, RetireCount=0.
- Reset asserted mid-operation discards the in-flight instruction immediately. There is no write on the following edge.
- Register update on the rising clk edge, priority highest first:
  1. FlushW=1: valid_q=0, regwrite_q=0, rd_q=0, data registers=0. Flush beats stall.
  2. StallW=1: all registers hold.
  3. Otherwise: capture ValidM, RegWriteM, ResultSrcM, Funct3M, ALUResultM, ReadDataM, PCPlus4M, RdM.
- Latency: one cycle from M inputs to W outputs.
- ResultW is combinational from registered values only. No path from M inputs to any W output.
- Load extract, using registered ALUResult[1:0] as byte offset:
  - LB/LBU select byte[offset]; sign- or zero-extend.
  - LH/LHU select halfword at offset[1]; offset[0] ignored; sign- or zero-extend.
  - LW passes the word through; offset ignored.
  - Any other funct3 passes the raw word through.
- ResultW mux on ResultSrc: 00 ALUResult, 01 load-extract, 10 PCPlus4, 11 ALUResult.
- RegWriteW = valid_q & regwrite_q & (rd_q != 0). x0 writes are suppressed here.
- ValidW = valid_q.
- Stall while ValidW=1: the same instruction is presented again next cycle. RegWriteW stays asserted, and the register-file rewrite is idempotent.

Optional Feature:
- Macro: MW_PIPE_STAGE_RETIRE_CNT_EN.
- Defined:
  - RetireCount port exists.
  - Counter increments on each rising edge where valid_q=1 and StallW=0 (instruction leaves WB), including when FlushW=1 on that edge.
  - Wraps modulo 2^CNT_WIDTH.
  - Cleared only by rst_n.
- Undefined: port and counter logic absent; all other behaviour identical.

Test Plan:
1. Reset released, ValidM=1, RegWriteM=1, RdM=5, ResultSrcM=00, ALUResultM=0x1234 -> next edge: ValidW=1, RegWriteW=1, RdW=5, ResultW=0x1234.
2. ResultSrcM=01, ReadDataM=0x80FF7F01, ALUResultM offset 2:
   - Funct3=000 (LB) -> ResultW=0xFFFFFFFF.
   - Funct3=100 (LBU) -> ResultW=0x000000FF.
   - Funct3=001 (LH) -> ResultW=0xFFFF80FF.
   - Funct3=101 (LHU) -> ResultW=0x000080FF.
   - Offset 0 with LB -> ResultW=0x00000001.
3. RdM=0, RegWriteM=1, ValidM=1 -> RegWriteW=0. ResultSrcM=10, PCPlus4M=0x104 -> ResultW=0x104.
4. Stall for 3 cycles while M inputs change -> W outputs hold the original values. FlushW=1 together with StallW=1 -> next edge ValidW=0, RegWriteW=0.
5. rst_n pulsed low between edges while ValidW=1 -> ValidW, RegWriteW and ResultW drop to 0 immediately, without waiting for clk.
6. With MW_PIPE_STAGE_RETIRE_CNT_EN and CNT_WIDTH=4: 17 valid unstalled retirements -> RetireCount=1 (wrap). Stalled cycles and bubbles do not increment it.
